// File: rtl/csa_acc_stream.sv
// Carry-save group accumulator: sums unsigned beats until in_last, then resolves S+C and holds the result.
// Latency: 2 edges from the accepting edge of the in_last beat to out_valid, independent of group length.
// Backpressure: in_ready is low in RESOLVE and HOLD; HOLD waits for out_ready with the outputs held stable.
module csa_acc_stream #(
    parameter int IN_W  = 13,
    parameter int ACC_W = 16,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [IN_W-1:0]  in_data,
    input  logic             in_valid,
    input  logic             in_last,
    output logic             in_ready,
    output logic [ACC_W-1:0] out_sum,
    output logic             out_ovf,
    output logic [CNT_W-1:0] out_count,
    output logic             out_valid,
    input  logic             out_ready
);

    generate
        if (ACC_W < IN_W + 1) begin : g_bad_width
            $error("csa_acc_stream: ACC_W must be at least IN_W+1");
        end
    endgenerate

    typedef enum logic [1:0] {
        ACCUM   = 2'd0,
        RESOLVE = 2'd1,
        HOLD    = 2'd2
    } state_t;

    state_t             state;
    logic [ACC_W-1:0]   s_r;
    logic [ACC_W-1:0]   c_r;
    logic               ovf_r;
    logic [CNT_W-1:0]   cnt_r;

    logic [ACC_W-1:0]   in_ext;
    logic [ACC_W-1:0]   s_nxt;
    logic [ACC_W-1:0]   maj;
    logic [ACC_W:0]     sum_full;

    assign in_ext   = ACC_W'(in_data);
    assign s_nxt    = in_ext ^ s_r ^ c_r;
    assign maj      = (in_ext & s_r) | (in_ext & c_r) | (s_r & c_r);
    assign sum_full = {1'b0, s_r} + {1'b0, c_r};

    assign in_ready  = (state == ACCUM);
    assign out_valid = (state == HOLD);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ACCUM;
            s_r       <= '0;
            c_r       <= '0;
            ovf_r     <= 1'b0;
            cnt_r     <= '0;
            out_sum   <= '0;
            out_ovf   <= 1'b0;
            out_count <= '0;
        end else begin
            case (state)
                ACCUM: begin
                    if (in_valid) begin
                        s_r <= s_nxt;
                        // Top majority bit has no home in C; its weight is 2^ACC_W, so it is pure overflow.
                        c_r <= {maj[ACC_W-2:0], 1'b0};
                        if (maj[ACC_W-1]) begin
                            ovf_r <= 1'b1;
                        end
                        if (cnt_r != {CNT_W{1'b1}}) begin
                            cnt_r <= cnt_r + CNT_W'(1);
                        end
                        if (in_last) begin
                            state <= RESOLVE;
                        end
                    end
                end
                RESOLVE: begin
                    out_sum   <= sum_full[ACC_W-1:0];
                    out_ovf   <= ovf_r | sum_full[ACC_W];
                    out_count <= cnt_r;
                    s_r       <= '0;
                    c_r       <= '0;
                    ovf_r     <= 1'b0;
                    cnt_r     <= '0;
                    state     <= HOLD;
                end
                HOLD: begin
                    if (out_ready) begin
                        state <= ACCUM;
                    end
                end
                default: begin
                    state <= ACCUM;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_csa_acc_stream.sv
// Directed bench for csa_acc_stream: a reference model pushes expected group results, a monitor pops them on handshake.
module tb_csa_acc_stream;

    logic        clk;
    logic        rst_n;
    logic [12:0] in_data;
    logic        in_valid;
    logic        in_last;
    logic        in_ready;
    logic [15:0] out_sum;
    logic        out_ovf;
    logic [7:0]  out_count;
    logic        out_valid;
    logic        out_ready;

    csa_acc_stream #(.IN_W(13), .ACC_W(16), .CNT_W(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_last   (in_last),
        .in_ready  (in_ready),
        .out_sum   (out_sum),
        .out_ovf   (out_ovf),
        .out_count (out_count),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] sum;
        logic        ovf;
        logic [7:0]  cnt;
    } exp_t;

    exp_t q[$];
    int   n_vec = 0;
    int   n_err = 0;
    int   n_out = 0;
    int   mdl_sum = 0;
    int   mdl_cnt = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    // Drive one beat, wait (bounded) for acceptance, and advance the reference model.
    task automatic beat(input logic [12:0] d, input logic l);
        int   k;
        exp_t e;
        k = 0;
        in_data  = d;
        in_last  = l;
        in_valid = 1'b1;
        while (!in_ready && k < 200) begin
            @(negedge clk);
            k++;
        end
        if (k >= 200) begin
            n_vec++;
            n_err++;
            $error("FAIL accept_wait: observed no in_ready expected in_ready within 200 cycles");
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        mdl_sum += int'(d);
        mdl_cnt++;
        if (l) begin
            e.sum = 16'(mdl_sum);
            e.ovf = (mdl_sum >= 65536);
            e.cnt = (mdl_cnt > 255) ? 8'd255 : 8'(mdl_cnt);
            q.push_back(e);
            mdl_sum = 0;
            mdl_cnt = 0;
        end
    endtask

    task automatic wait_idle();
        int k;
        k = 0;
        while ((q.size() != 0 || !in_ready) && k < 100) begin
            @(negedge clk);
            k++;
        end
        check("idle_wait", 32'(k < 100), 32'd1);
    endtask

    always @(negedge clk) begin : monitor
        exp_t e;
        if (rst_n && out_valid && out_ready) begin
            n_out++;
            n_vec++;
            assert (q.size() != 0) else begin
                n_err++;
                $error("FAIL spurious_out: observed sum %0h expected no output", out_sum);
            end
            if (q.size() != 0) begin
                e = q.pop_front();
                check("out_sum", 32'(out_sum), 32'(e.sum));
                check("out_ovf", 32'(out_ovf), 32'(e.ovf));
                check("out_count", 32'(out_count), 32'(e.cnt));
            end
        end
    end

    initial begin
        rst_n     = 1'b0;
        in_data   = '0;
        in_valid  = 1'b0;
        in_last   = 1'b0;
        out_ready = 1'b1;

        repeat (2) @(negedge clk);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_sum", 32'(out_sum), 32'd0);
        check("rst_out_count", 32'(out_count), 32'd0);
        check("rst_out_ovf", 32'(out_ovf), 32'd0);
        rst_n = 1'b1;

        // Single beat: result two edges after acceptance, valid for exactly one cycle.
        beat(13'h1ABC, 1'b1);
        @(negedge clk);
        check("single_resolve_valid", 32'(out_valid), 32'd0);
        check("single_resolve_ready", 32'(in_ready), 32'd0);
        @(negedge clk);
        check("single_hold_valid", 32'(out_valid), 32'd1);
        @(negedge clk);
        check("single_after_valid", 32'(out_valid), 32'd0);
        check("single_after_ready", 32'(in_ready), 32'd1);
        wait_idle();

        for (int i = 0; i < 4; i++) beat(13'h1FFF, i == 3);
        wait_idle();

        for (int i = 0; i < 9; i++) beat(13'h1FFF, i == 8);
        wait_idle();

        // Back-pressure with a beat already waiting on the input.
        out_ready = 1'b0;
        beat(13'h0123, 1'b0);
        beat(13'h0456, 1'b1);
        in_data  = 13'h0007;
        in_last  = 1'b1;
        in_valid = 1'b1;
        begin
            int k;
            k = 0;
            while (!out_valid && k < 10) begin
                @(negedge clk);
                k++;
            end
            check("bp_valid_wait", 32'(k < 10), 32'd1);
        end
        for (int i = 0; i < 5; i++) begin
            check("bp_hold_valid", 32'(out_valid), 32'd1);
            check("bp_hold_ready", 32'(in_ready), 32'd0);
            check("bp_hold_sum", 32'(out_sum), 32'h579);
            check("bp_hold_count", 32'(out_count), 32'd2);
            @(negedge clk);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        q.push_back('{sum: 16'h0007, ovf: 1'b0, cnt: 8'd1});
        @(posedge clk);
        #1;
        check("bp_handshake_ready", 32'(in_ready), 32'd1);
        check("bp_handshake_valid", 32'(out_valid), 32'd0);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        check("bp_late_accept", 32'(in_ready), 32'd0);
        check("bp_late_accept_valid", 32'(out_valid), 32'd0);
        wait_idle();

        for (int i = 0; i < 300; i++) beat(13'h0001, i == 299);
        wait_idle();

        // Reset while a result sits in HOLD: it must never be emitted.
        out_ready = 1'b0;
        beat(13'h0033, 1'b1);
        repeat (2) @(negedge clk);
        check("hold_before_reset", 32'(out_valid), 32'd1);
        #1 rst_n = 1'b0;
        #1;
        check("hold_rst_valid", 32'(out_valid), 32'd0);
        check("hold_rst_ready", 32'(in_ready), 32'd1);
        check("hold_rst_sum", 32'(out_sum), 32'd0);
        check("hold_rst_count", 32'(out_count), 32'd0);
        q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        out_ready = 1'b1;

        // Reset mid-group, then a fresh one-beat group accepted on the first edge.
        beat(13'h0100, 1'b0);
        beat(13'h0100, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_ready", 32'(in_ready), 32'd1);
        mdl_sum = 0;
        mdl_cnt = 0;
        @(negedge clk);
        rst_n = 1'b1;
        beat(13'h0005, 1'b1);
        @(negedge clk);
        check("post_rst_first_edge", 32'(in_ready), 32'd0);
        wait_idle();

        repeat (5) @(negedge clk);
        check("emitted_groups", 32'(n_out), 32'd7);
        check("queue_drained", 32'(q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
